// File: rtl/scie_fir_sequencer.sv
// Issue stage for the SCIE pipelined FIR accelerator: loads TAPS coefficients, then turns
// each sample into a push/read instruction pair and returns the accelerator's rd result.
module scie_fir_sequencer #(
  parameter int          TAPS    = 5,
  parameter int          XLEN    = 32,
  parameter logic [31:0] OP_COEF = 32'd11,
  parameter logic [31:0] OP_PUSH = 32'd43,
  parameter logic [31:0] OP_READ = 32'd91,
  parameter int          GAP     = 2,
  parameter int          RD_LAT  = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] cfg_coef,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            coef_loaded,
  output logic            scie_valid,
  output logic [31:0]     scie_insn,
  output logic [XLEN-1:0] scie_rs1,
  output logic [XLEN-1:0] scie_rs2,
  input  logic [XLEN-1:0] scie_rd
);

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_PUSH, S_WAIT, S_READ, S_CAPT, S_HOLD
  } state_e;

  localparam int                IDX_W     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int                CNT_W     = 8;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  WAIT_INIT = (GAP > 1) ? CNT_W'(GAP - 2) : '0;
  localparam logic [CNT_W-1:0]  CAPT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              loaded_q, loaded_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              sv_q, sv_d;
  logic [31:0]       insn_q, insn_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;

  logic cfg_fire, in_fire, out_fire;
  assign cfg_fire = cfg_valid & cfg_ready_q;
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // scie_rd is sampled at the end of the RD_LAT-th cycle counting the read-issue cycle,
  // so accept edge -> out_valid is 1 + GAP + RD_LAT cycles.
  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    loaded_d    = loaded_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sv_d        = 1'b0;
    insn_d      = '0;
    rs1_d       = '0;
    rs2_d       = '0;

    if (clear && state_q != S_LOAD && state_q != S_IDLE) pend_d = 1'b1;

    unique case (state_q)
      S_LOAD: begin
        if (clear) begin
          idx_d    = '0;
          loaded_d = 1'b0;
        end else if (cfg_fire) begin
          sv_d   = 1'b1;
          insn_d = OP_COEF;
          rs1_d  = cfg_coef;
          rs2_d  = XLEN'(idx_q);
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_IDLE: begin
        // An accepted sample is never dropped: a coincident clear is deferred until it completes.
        if (in_fire) begin
          sv_d    = 1'b1;
          insn_d  = OP_PUSH;
          rs1_d   = in_data;
          pend_d  = clear;
          state_d = S_PUSH;
        end else if (clear) begin
          idx_d    = '0;
          loaded_d = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_PUSH: begin
        if (GAP > 1) begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end else begin
          sv_d    = 1'b1;
          insn_d  = OP_READ;
          state_d = S_READ;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          sv_d    = 1'b1;
          insn_d  = OP_READ;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ: begin
        if (RD_LAT > 1) begin
          cnt_d   = CAPT_INIT;
          state_d = S_CAPT;
        end else begin
          out_data_d  = scie_rd;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_CAPT: begin
        if (cnt_q == '0) begin
          out_data_d  = scie_rd;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (pend_q || clear) begin
            pend_d   = 1'b0;
            idx_d    = '0;
            loaded_d = 1'b0;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    cfg_ready_d = (state_d == S_LOAD);
    in_ready_d  = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      loaded_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sv_q        <= 1'b0;
      insn_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      loaded_q    <= loaded_d;
      cfg_ready_q <= cfg_ready_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sv_q        <= sv_d;
      insn_q      <= insn_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign coef_loaded = loaded_q;
  assign scie_valid  = sv_q;
  assign scie_insn   = insn_q;
  assign scie_rs1    = rs1_q;
  assign scie_rs2    = rs2_q;

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// Randomized bench for scie_fir_sequencer: a behavioural FIR accelerator answers the SCIE bus,
// and expected results come from an independent convolution over the stimulus the bench sent.
module tb_scie_fir_sequencer;

  localparam int          TAPS    = 5;
  localparam int          XLEN    = 32;
  localparam logic [31:0] OP_COEF = 32'd11;
  localparam logic [31:0] OP_PUSH = 32'd43;
  localparam logic [31:0] OP_READ = 32'd91;
  localparam int          GAP     = 2;
  localparam int          RD_LAT  = 1;
  localparam int          LAT     = 1 + GAP + RD_LAT;

  logic            clock = 1'b0;
  logic            reset, clear, cfg_valid, in_valid, out_ready;
  logic [XLEN-1:0] cfg_coef, in_data;
  logic            cfg_ready, in_ready, out_valid, coef_loaded, scie_valid;
  logic [XLEN-1:0] out_data, scie_rs1, scie_rs2, scie_rd;
  logic [31:0]     scie_insn;

  int checks = 0;
  int failures = 0;

  scie_fir_sequencer #(
    .TAPS(TAPS), .XLEN(XLEN), .OP_COEF(OP_COEF), .OP_PUSH(OP_PUSH),
    .OP_READ(OP_READ), .GAP(GAP), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_coef(cfg_coef),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_loaded(coef_loaded), .scie_valid(scie_valid), .scie_insn(scie_insn),
    .scie_rs1(scie_rs1), .scie_rs2(scie_rs2), .scie_rd(scie_rd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Accelerator model: FIR over its own coefficient and sample memories. With RD_LAT=1 the
  // result is presented during the read-issue cycle; any other cycle shows junk on rd.
  logic [31:0] acc_coef [TAPS];
  logic [31:0] acc_hist [TAPS];
  logic [31:0] acc_sum;
  bit          acc_ovr_en = 1'b0;
  logic [31:0] acc_ovr = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        acc_coef[i] <= '0;
        acc_hist[i] <= '0;
      end
    end else if (scie_valid) begin
      if (scie_insn == OP_COEF && scie_rs2 < TAPS) acc_coef[scie_rs2] <= scie_rs1;
      if (scie_insn == OP_PUSH) begin
        acc_hist[0] <= scie_rs1;
        for (int i = 1; i < TAPS; i++) acc_hist[i] <= acc_hist[i-1];
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < TAPS; i++) acc_sum = acc_sum + acc_coef[i] * acc_hist[i];
  end

  assign scie_rd = (scie_valid && scie_insn == OP_READ) ? (acc_ovr_en ? acc_ovr : acc_sum)
                                                        : 32'hDEAD_BEEF;

  // Idle bus must carry zeros in every cycle outside reset.
  always @(negedge clock)
    if (reset && !scie_valid) check("scie_idle_zero", scie_insn | scie_rs1 | scie_rs2, 32'd0);

  // Reference: y[n] = sum_i coef[i] * x[n-i] over samples pushed since reset (newest first).
  logic [31:0] ref_coef [TAPS];
  logic [31:0] ref_hist [$];

  function automatic logic [31:0] ref_fir();
    logic [31:0] s = '0;
    for (int i = 0; i < TAPS; i++)
      if (i < ref_hist.size()) s = s + ref_coef[i] * ref_hist[i];
    return s;
  endfunction

  task automatic wait_cfg_ready();
    int n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_beat(input int idx, input logic [31:0] c);
    wait_cfg_ready();
    check("load_in_ready", 32'(in_ready), 32'd0);
    cfg_valid = 1'b1;
    cfg_coef  = c;
    @(negedge clock);
    cfg_valid = 1'b0;
    check("coef_valid", 32'(scie_valid), 32'd1);
    check("coef_insn", scie_insn, OP_COEF);
    check("coef_rs1", scie_rs1, c);
    check("coef_rs2", scie_rs2, 32'(idx));
  endtask

  task automatic load_all();
    for (int i = 0; i < TAPS; i++) send_beat(i, ref_coef[i]);
    check("loaded", 32'(coef_loaded), 32'd1);
    check("loaded_cfg_ready", 32'(cfg_ready), 32'd0);
    check("loaded_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < TAPS; i++) ref_coef[i] = $urandom_range(0, 65535);
  endtask

  task automatic run_sample(input logic [31:0] x, input bit use_ovr, input logic [31:0] ovr,
                            input int hold, input int clear_at, input bit expect_load);
    logic [31:0] exp;
    wait_in_ready();
    acc_ovr_en = use_ovr;
    acc_ovr    = ovr;
    ref_hist.push_front(x);
    if (ref_hist.size() > TAPS) void'(ref_hist.pop_back());
    exp = use_ovr ? ovr : ref_fir();
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 1; t <= LAT; t++) begin
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = $urandom;
      clear    = (t == clear_at);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      if (t == 1) begin
        check("push_valid", 32'(scie_valid), 32'd1);
        check("push_insn", scie_insn, OP_PUSH);
        check("push_rs1", scie_rs1, x);
        check("push_rs2", scie_rs2, 32'd0);
      end else if (t == 1 + GAP) begin
        check("read_valid", 32'(scie_valid), 32'd1);
        check("read_insn", scie_insn, OP_READ);
        check("read_rs", scie_rs1 | scie_rs2, 32'd0);
      end else begin
        check("gap_valid", 32'(scie_valid), 32'd0);
      end
      check("out_valid_timing", 32'(out_valid), 32'(t == LAT));
    end
    clear = 1'b0;
    check("out_data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, exp);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_scie", 32'(scie_valid), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    if (expect_load) begin
      check("post_cfg_ready", 32'(cfg_ready), 32'd1);
      check("post_coef_loaded", 32'(coef_loaded), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd0);
    end else begin
      check("post_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] plan_coefs [TAPS];
    plan_coefs = '{32'd24438, 32'd28656, 32'd16802, 32'd34393, 32'd24882};
    reset = 1'b0; clear = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_coef = '0; in_data = '0;
    repeat (3) @(negedge clock);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_outs", 32'({in_ready, out_valid, coef_loaded, scie_valid}), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b1;

    // Plan-value load, back to back.
    for (int i = 0; i < TAPS; i++) ref_coef[i] = plan_coefs[i];
    load_all();

    run_sample(32'd16592, 1'b1, 32'd6187, 0, 0, 1'b0);
    run_sample($urandom_range(0, 65535), 1'b1, 32'd16461, 3, 0, 1'b0);
    run_sample(32'd39032, 1'b1, 32'd29604, 0, 2, 1'b1);
    rand_coefs();
    load_all();
    run_sample($urandom_range(0, 65535), 1'b0, '0, 1, 0, 1'b0);

    // Reset while the read is on the bus.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 32'd777;
    for (int t = 1; t <= 1 + GAP; t++) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    check("pre_rst_read", scie_insn, OP_READ);
    #2 reset = 1'b0;
    #1;
    check("arst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("arst_flags", 32'({in_ready, out_valid, coef_loaded, scie_valid}), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_bus", scie_insn | scie_rs1 | scie_rs2, 32'd0);
    ref_hist.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      check("post_rst_scie", 32'(scie_valid), 32'd0);
      check("post_rst_loaded", 32'(coef_loaded), 32'd0);
    end
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rand_coefs();
    load_all();

    // Clear coincident with the third beat of a reload.
    acc_ovr_en = 1'b0;
    run_sample($urandom_range(0, 65535), 1'b0, '0, 0, 0, 1'b0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("idle_clear_cfg_ready", 32'(cfg_ready), 32'd1);
    check("idle_clear_loaded", 32'(coef_loaded), 32'd0);
    rand_coefs();
    send_beat(0, ref_coef[0]);
    send_beat(1, ref_coef[1]);
    cfg_valid = 1'b1;
    cfg_coef  = 32'd55555;
    clear     = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    clear     = 1'b0;
    check("clr_beat_dropped", 32'(scie_valid), 32'd0);
    check("clr_cfg_ready", 32'(cfg_ready), 32'd1);
    load_all();

    // Random samples through the FIR reference.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_sample($urandom_range(0, 65535), 1'b0, '0, $urandom_range(0, 2), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
